qspi_flash_sequencer: RTL

- Op-level controller placed in front of dword_interface (header/payload word port into qspi_mem_controller).
- Accepts one flash request at a time: read status, 4 KB sector erase, page program, 64-bit read.
- Expands each request into the required SPI transactions (write-enable, command, status polling).
- Drives if_wr/if_data and sequences on if_busy; returns status, read data and an error flag.

---
 rtl/qspi_flash_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_flash_sequencer.sv
// qspi_flash_sequencer: op-level controller in front of dword_interface.
// Expands one flash request (RDSR / sector erase / page program / read) into
// header+payload word transactions, with write-enable and WIP status polling.
// Optional feature macro: SEQ_QUAD_READ_EN (quad-output fast read 0x6B with a
// dummy word instead of single-line 0x03).
module qspi_flash_sequencer #(
  parameter int unsigned MAX_PP_WORDS = 7,
  parameter int unsigned POLL_LIMIT   = 65535,
  parameter int unsigned POLL_GAP     = 16
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [2:0]  req_words,
  input  logic [31:0] prog_data,
  input  logic        prog_valid,
  output logic        prog_ready,
  output logic        done,
  output logic        err,
  output logic [7:0]  status,
  output logic [63:0] rd_data,
  output logic        if_wr,
  output logic [31:0] if_data,
  input  logic        if_busy,
  input  logic        if_error,
  input  logic [63:0] if_readout
);

  localparam logic [1:0] ReqRdsr  = 2'd0;
  localparam logic [1:0] ReqErase = 2'd1;
  localparam logic [1:0] ReqProg  = 2'd2;
  localparam logic [1:0] ReqRead  = 2'd3;

  typedef enum logic [2:0] {OpIdle, OpWren, OpCmd, OpPollGap, OpPoll, OpFinish} op_state_e;
  typedef enum logic [1:0] {THdr, TPay, TWait, TDone} tx_state_e;

  op_state_e   op_q;
  tx_state_e   tx_q;
  logic [1:0]  kind_q;
  logic [23:0] addr_q;
  logic [6:0]  nwords_q;
  logic [6:0]  idx_q;
  logic        wait_first_q;
  logic [15:0] gap_q;
  logic [15:0] polls_q;
  logic        err_q;
  logic [7:0]  status_q;
  logic [63:0] rd_data_q;

  // Program word count: 0 means one word, clamp to the per-page maximum.
  logic [6:0] req_n;
  always_comb begin
    req_n = (req_words == 3'd0) ? 7'd1 : {4'd0, req_words};
    if (32'(req_n) > MAX_PP_WORDS) req_n = 7'(MAX_PP_WORDS);
  end

  // Describe the transaction belonging to the current op step.
  logic        tx_quad;
  logic [6:0]  tx_len;
  logic [11:0] tx_out;
  logic [11:0] tx_in;
  logic [31:0] tx_word;
  logic        tx_is_data;
  always_comb begin
    tx_quad    = 1'b0;
    tx_len     = 7'd1;
    tx_out     = 12'd0;
    tx_in      = 12'd8;
    tx_word    = 32'h0600_0000;
    tx_is_data = 1'b0;
    if (op_q == OpPoll) begin
      tx_out  = 12'd8;
      tx_word = 32'h0500_0000;
    end else if (op_q == OpCmd) begin
      unique case (kind_q)
        ReqRdsr: begin
          tx_out  = 12'd8;
          tx_word = 32'h0500_0000;
        end
        ReqErase: begin
          tx_in   = 12'd32;
          tx_word = {8'h20, addr_q};
        end
        ReqProg: begin
          tx_len     = nwords_q + 7'd1;
          tx_in      = {nwords_q + 7'd1, 5'd0};
          tx_is_data = (idx_q != 7'd0);
          tx_word    = tx_is_data ? prog_data : {8'h02, addr_q};
        end
        ReqRead: begin
          tx_out = 12'd64;
`ifdef SEQ_QUAD_READ_EN
          tx_quad = 1'b1;
          tx_len  = 7'd2;
          tx_in   = 12'd40;
          tx_word = (idx_q == 7'd0) ? {8'h6B, addr_q} : 32'h0;
`else
          tx_in   = 12'd32;
          tx_word = {8'h03, addr_q};
`endif
        end
      endcase
    end
  end

  // Word port drive: header once the interface is free, then payload words.
  // Program data words stall while no data is offered.
  always_comb begin
    if_wr      = 1'b0;
    if_data    = 32'h0;
    prog_ready = 1'b0;
    if (op_q == OpWren || op_q == OpCmd || op_q == OpPoll) begin
      if (tx_q == THdr && !if_busy) begin
        if_wr   = 1'b1;
        if_data = {tx_quad, tx_len, tx_out, tx_in};
      end else if (tx_q == TPay && (!tx_is_data || prog_valid)) begin
        if_wr      = 1'b1;
        if_data    = tx_word;
        prog_ready = tx_is_data;
      end
    end
  end

  assign req_ready = (op_q == OpIdle) && !if_busy;
  assign done      = (op_q == OpFinish);
  assign err       = err_q;
  assign status    = status_q;
  assign rd_data   = rd_data_q;

  // Op and transaction sequencing with latched request and result registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      op_q         <= OpIdle;
      tx_q         <= THdr;
      kind_q       <= ReqRdsr;
      addr_q       <= 24'h0;
      nwords_q     <= 7'd1;
      idx_q        <= 7'd0;
      wait_first_q <= 1'b0;
      gap_q        <= 16'd0;
      polls_q      <= 16'd0;
      err_q        <= 1'b0;
      status_q     <= 8'h0;
      rd_data_q    <= 64'h0;
    end else begin
      unique case (op_q)
        OpIdle: begin
          if (req_valid && req_ready) begin
            kind_q   <= req_op;
            addr_q   <= req_addr;
            nwords_q <= req_n;
            err_q    <= 1'b0;
            polls_q  <= 16'd0;
            tx_q     <= THdr;
            op_q     <= (req_op == ReqRdsr || req_op == ReqRead) ? OpCmd : OpWren;
          end
        end
        OpPollGap: begin
          if (32'(gap_q) + 32'd1 >= POLL_GAP) begin
            op_q <= OpPoll;
            tx_q <= THdr;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        OpFinish: op_q <= OpIdle;
        default: begin
          unique case (tx_q)
            THdr: begin
              if (!if_busy) begin
                tx_q  <= TPay;
                idx_q <= 7'd0;
              end
            end
            TPay: begin
              if (if_wr) begin
                if (idx_q == tx_len - 7'd1) begin
                  tx_q         <= TWait;
                  wait_first_q <= 1'b1;
                end else begin
                  idx_q <= idx_q + 7'd1;
                end
              end
            end
            // busy only rises the cycle after the header, so skip one sample.
            TWait: begin
              wait_first_q <= 1'b0;
              if (!wait_first_q && !if_busy) tx_q <= TDone;
            end
            TDone: begin
              tx_q <= THdr;
              if (if_error) begin
                err_q <= 1'b1;
                op_q  <= OpFinish;
              end else if (op_q == OpWren) begin
                op_q <= OpCmd;
              end else if (op_q == OpCmd) begin
                if (kind_q == ReqRdsr) begin
                  status_q <= if_readout[7:0];
                  op_q     <= OpFinish;
                end else if (kind_q == ReqRead) begin
                  rd_data_q <= if_readout;
                  op_q      <= OpFinish;
                end else begin
                  gap_q <= 16'd0;
                  op_q  <= OpPollGap;
                end
              end else begin
                status_q <= if_readout[7:0];
                if (polls_q != 16'hFFFF) polls_q <= polls_q + 16'd1;
                if (!if_readout[0]) begin
                  op_q <= OpFinish;
                end else if (32'(polls_q) + 32'd1 >= POLL_LIMIT) begin
                  err_q <= 1'b1;
                  op_q  <= OpFinish;
                end else begin
                  gap_q <= 16'd0;
                  op_q  <= OpPollGap;
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
